sigmoid_rr_sched: RTL and testbench

Round-robin scheduler that shares one pipelined sigmoid evaluation core between NREQ requesters.
- Accepts 8-bit x operands over per-requester valid/ready.
- Issues at most one operand per cycle to the core.
- Tracks the owner of each in-flight operand in a tag pipeline and returns the 16-bit result with the requester ID.
- Sits between the requesting datapaths and the sigmoid core. Also flags core valid/timing mismatches.

---
 rtl/sigmoid_pkg.sv | 19 +
 rtl/sig_rr_arb.sv | 40 ++++
 rtl/sigmoid_rr_sched.sv | 171 +++++++++++++++++
 tb/tb_sigmoid_rr_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_pkg.sv
// Shared constants and types for the sigmoid scheduler slice.
// Operand/result widths, default core latency and the requester limit
// live here so the arbiter, the scheduler and any core wrapper agree.
package sigmoid_pkg;

    localparam int X_W          = 8;   // operand width presented to the core
    localparam int Y_W          = 16;  // result width returned by the core
    localparam int SIG_CORE_LAT = 3;   // default core latency in cycles
    localparam int SIG_NREQ_MAX = 8;   // largest supported requester count

    typedef logic [X_W-1:0] sig_x_t;
    typedef logic [Y_W-1:0] sig_y_t;

    // Next requester index after idx in cyclic order over n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sig_rr_arb.sv
// Combinational round-robin arbiter for the sigmoid scheduler.
// Searches req_valid starting at ptr and wrapping around; the first hit is
// the candidate g. The one-hot grant is suppressed while hold is high, but
// the candidate index is still reported so the caller can decide.
module sig_rr_arb
    import sigmoid_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
)
(
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            hold,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_any
);

    logic [IDW-1:0] idx;

    // Cyclic priority search from ptr; first valid requester wins.
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        grant   = '0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
        if (gnt_any && !hold) begin
            grant[gnt_id] = 1'b1;
        end
    end

endmodule

// File: rtl/sigmoid_rr_sched.sv
// Round-robin scheduler sharing one pipelined sigmoid core among NREQ
// requesters. One operand per cycle is issued; a tag pipe LAT+1 deep
// remembers who owns each in-flight operand so the result can be routed
// back with its requester ID. Core strobes that disagree with the tag pipe
// raise a sticky error, except in a short window after reset where strobes
// from discarded work are still draining out of the core.
module sigmoid_rr_sched
    import sigmoid_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = SIG_CORE_LAT
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*X_W-1:0] req_x,
    output logic [NREQ-1:0]     req_ready,
    input  logic                hold,
    output logic                core_in_valid,
    output logic [X_W-1:0]      core_x,
    input  logic [Y_W-1:0]      core_y,
    input  logic                core_out_valid,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [Y_W-1:0]      rsp_y,
    output logic                busy,
    output logic                err
);

    // Mask counter must hold LAT+1.
    localparam int MCW = $clog2(LAT + 2);

    if (IDW != $clog2(NREQ) || NREQ < 2 || NREQ > SIG_NREQ_MAX) begin : g_bad_cfg
        $error("sigmoid_rr_sched: NREQ must be 2..SIG_NREQ_MAX and IDW = clog2(NREQ)");
    end

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_any;
    logic            accept;
    logic [IDW-1:0]  ptr;
    sig_x_t          sel_x;

    // Tag pipe: index i holds the operand that was accepted i+1 cycles ago.
    logic            tag_vld_p [0:LAT];
    logic [IDW-1:0]  tag_id_p  [0:LAT];
    logic            tag_any;

    logic            exp_vld;
    logic [IDW-1:0]  exp_id;

    logic [MCW-1:0]  mask_cnt;
    logic            chk_en;

    // Reset forces the arbiter quiet exactly like hold does.
    sig_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr),
        .hold      (hold | rst),
        .grant     (grant),
        .gnt_id    (gnt_id),
        .gnt_any   (gnt_any)
    );

    assign req_ready = grant;
    assign accept    = gnt_any & ~hold & ~rst;

    // Route the granted requester's operand toward the issue register.
    always_comb begin
        sel_x = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_id == IDW'(k)) begin
                sel_x = req_x[k*X_W +: X_W];
            end
        end
    end

    // Round-robin pointer: moves past the winner on accept, frozen otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= IDW'(rr_next(int'(gnt_id), NREQ));
        end
    end

    // ---- stage p0: issue register toward the core ----
    // Operand is zeroed on idle cycles so the core input is deterministic.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_in_valid <= 1'b0;
            core_x        <= '0;
        end else begin
            core_in_valid <= accept;
            core_x        <= accept ? sel_x : '0;
        end
    end

    // ---- tag pipe: ownership of each in-flight operand ----
    // Shifts every cycle regardless of hold so in-flight work always drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= LAT; i++) begin
                tag_vld_p[i] <= 1'b0;
                tag_id_p[i]  <= '0;
            end
        end else begin
            tag_vld_p[0] <= accept;
            tag_id_p[0]  <= gnt_id;
            for (int i = 1; i <= LAT; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
                tag_id_p[i]  <= tag_id_p[i-1];
            end
        end
    end

    // The oldest tag lines up with the core's output strobe.
    assign exp_vld = tag_vld_p[LAT];
    assign exp_id  = tag_id_p[LAT];

    // Any live tag means work is still owed to some requester.
    always_comb begin
        tag_any = 1'b0;
        for (int i = 0; i <= LAT; i++) begin
            tag_any = tag_any | tag_vld_p[i];
        end
    end

    // ---- response stage: capture core result with its owner ----
    // A result only counts when the tag pipe expects one; stray strobes drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
        end else begin
            rsp_valid <= exp_vld & core_out_valid;
            rsp_id    <= exp_id;
            rsp_y     <= core_y;
        end
    end

    // Post-reset mask: the core may still emit strobes for discarded work.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_cnt <= MCW'(LAT + 1);
        end else if (mask_cnt != '0) begin
            mask_cnt <= mask_cnt - MCW'(1);
        end
    end

    assign chk_en = (mask_cnt == '0);

    // Sticky protocol error: core strobe disagrees with the expected slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (chk_en && (core_out_valid != exp_vld)) begin
            err <= 1'b1;
        end
    end

    // Busy covers the accept cycle itself through the final response cycle.
    assign busy = ~rst & (accept | tag_any | core_in_valid | rsp_valid);

endmodule

// File: tb/tb_sigmoid_rr_sched.sv
// Directed bench for sigmoid_rr_sched with a latency-LAT core model.
module tb_sigmoid_rr_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 3;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_x;
    logic [3:0]  req_ready;
    logic        hold;
    logic        core_in_valid;
    logic [7:0]  core_x;
    logic [15:0] core_y;
    logic        core_out_valid;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_y;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int a0;

    typedef struct {
        int          c;
        logic [1:0]  id;
        logic [15:0] y;
    } rsp_t;
    rsp_t rsp_q[$];

    sigmoid_rr_sched #(
        .NREQ (NREQ),
        .IDW  (IDW),
        .LAT  (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_x          (req_x),
        .req_ready      (req_ready),
        .hold           (hold),
        .core_in_valid  (core_in_valid),
        .core_x         (core_x),
        .core_y         (core_y),
        .core_out_valid (core_out_valid),
        .rsp_valid      (rsp_valid),
        .rsp_id         (rsp_id),
        .rsp_y          (rsp_y),
        .busy           (busy),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference "sigmoid": 0x00 -> 0x8000, monotone in signed x.
    function automatic logic [15:0] y_of(input logic [7:0] x);
        return {x ^ 8'h80, 8'h00};
    endfunction

    // Core model: fixed latency LAT, optional suppression of one issue.
    logic       mv [0:LAT-1];
    logic       md [0:LAT-1];
    logic [7:0] mx [0:LAT-1];
    int issue_cnt = 0;
    int drop_at   = -1;

    always @(posedge clk) begin
        mv[0] <= core_in_valid;
        mx[0] <= core_x;
        md[0] <= core_in_valid && (issue_cnt == drop_at);
        if (core_in_valid) issue_cnt <= issue_cnt + 1;
        for (int i = 1; i < LAT; i++) begin
            mv[i] <= mv[i-1];
            mx[i] <= mx[i-1];
            md[i] <= md[i-1];
        end
    end

    assign core_out_valid = mv[LAT-1] & ~md[LAT-1];
    assign core_y         = core_out_valid ? y_of(mx[LAT-1]) : 16'h0000;

    // Response monitor.
    always @(negedge clk) begin
        if (rsp_valid) rsp_q.push_back('{cyc, rsp_id, rsp_y});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges, then release; returns in the first post-reset cycle.
    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        hold      = 1'b0;
        step();
        step();
        rsp_q.delete();
        rst = 1'b0;
        a0  = cyc;
    endtask

    task automatic chk_rsp(input string tag, input int idx, input int c,
                           input logic [1:0] id, input logic [15:0] y);
        if (idx < rsp_q.size()) begin
            chk($sformatf("%s_cyc", tag), rsp_q[idx].c - a0, c);
            chk($sformatf("%s_id", tag), {30'd0, rsp_q[idx].id}, {30'd0, id});
            chk($sformatf("%s_y", tag), {16'd0, rsp_q[idx].y}, {16'd0, y});
        end else begin
            chk($sformatf("%s_missing", tag), 32'd0, 32'd1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        req_x     = 32'h0;
        hold      = 1'b0;

        // ---- T0: reset state ----
        step(); step(); step();
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_civ", {31'd0, core_in_valid}, 32'd0);
        chk("rst_core_x", {24'd0, core_x}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("rst_rsp_y", {16'd0, rsp_y}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // ---- T1: single request from requester 2, x=0x00 ----
        do_reset();
        req_x = 32'h7700_3311;
        for (int c = 0; c < 8; c++) begin
            req_valid = (c == 0) ? 4'b0100 : 4'b0000;
            #1;
            if (c == 0) chk("t1_ready", {28'd0, req_ready}, 32'h4);
            if (c == 1) begin
                chk("t1_civ", {31'd0, core_in_valid}, 32'd1);
                chk("t1_core_x", {24'd0, core_x}, 32'h00);
            end
            if (c == 2) chk("t1_civ_idle", {31'd0, core_in_valid}, 32'd0);
            chk($sformatf("t1_rsp_valid_c%0d", c), {31'd0, rsp_valid}, (c == 5) ? 32'd1 : 32'd0);
            chk($sformatf("t1_busy_c%0d", c), {31'd0, busy}, (c <= 5) ? 32'd1 : 32'd0);
            if (c == 5) begin
                chk("t1_rsp_id", {30'd0, rsp_id}, 32'd2);
                chk("t1_rsp_y", {16'd0, rsp_y}, 32'h8000);
            end
            chk($sformatf("t1_err_c%0d", c), {31'd0, err}, 32'd0);
            step();
        end

        // ---- T2: all four valid, back-to-back round robin ----
        do_reset();
        req_x = 32'h0302_0100;
        for (int c = 0; c < 16; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            chk($sformatf("t2_ready_c%0d", c), {28'd0, req_ready},
                (c < 8) ? (32'd1 << (c % 4)) : 32'd0);
            step();
        end
        chk("t2_count", rsp_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk_rsp($sformatf("t2_rsp%0d", i), i, 5 + i, 2'(i % 4), y_of(8'(i % 4)));
        end
        chk("t2_err", {31'd0, err}, 32'd0);

        // ---- T3: sparse requesters 1 and 3, then only 1 ----
        do_reset();
        req_x = 32'h1020_3040;
        for (int c = 0; c < 13; c++) begin
            logic [3:0] exp_rdy;
            req_valid = (c < 4) ? 4'b1010 : ((c < 7) ? 4'b0010 : 4'b0000);
            if (c < 4) exp_rdy = (c % 2 == 0) ? 4'b0010 : 4'b1000;
            else if (c < 7) exp_rdy = 4'b0010;
            else exp_rdy = 4'b0000;
            #1;
            chk($sformatf("t3_ready_c%0d", c), {28'd0, req_ready}, {28'd0, exp_rdy});
            step();
        end
        chk("t3_count", rsp_q.size(), 32'd7);

        // ---- T4: hold after two accepts, release from frozen ptr ----
        do_reset();
        req_x = 32'h0403_0201;
        for (int c = 0; c < 17; c++) begin
            logic [3:0] exp_rdy;
            hold      = (c >= 2 && c <= 8);
            req_valid = (c <= 9) ? 4'hF : 4'h0;
            if (c < 2) exp_rdy = 4'(1 << c);
            else if (c == 9) exp_rdy = 4'b0100;
            else exp_rdy = 4'b0000;
            #1;
            chk($sformatf("t4_ready_c%0d", c), {28'd0, req_ready}, {28'd0, exp_rdy});
            if (c >= 2 && c <= 8)
                chk($sformatf("t4_busy_c%0d", c), {31'd0, busy}, (c <= 6) ? 32'd1 : 32'd0);
            step();
        end
        hold = 1'b0;
        chk("t4_count", rsp_q.size(), 32'd3);
        chk_rsp("t4_rsp0", 0, 5, 2'd0, y_of(8'h01));
        chk_rsp("t4_rsp1", 1, 6, 2'd1, y_of(8'h02));
        chk_rsp("t4_rsp2", 2, 14, 2'd2, y_of(8'h03));

        // ---- T5: core drops the strobe for the second of three issues ----
        do_reset();
        req_x   = 32'h40C0_7F80;
        drop_at = issue_cnt + 1;
        for (int c = 0; c < 14; c++) begin
            req_valid = (c < 3) ? 4'b0111 : 4'b0000;
            #1;
            chk($sformatf("t5_err_c%0d", c), {31'd0, err}, (c >= 6) ? 32'd1 : 32'd0);
            step();
        end
        drop_at = -1;
        chk("t5_count", rsp_q.size(), 32'd2);
        chk_rsp("t5_rsp0", 0, 5, 2'd0, y_of(8'h80));
        chk_rsp("t5_rsp1", 1, 7, 2'd2, y_of(8'hC0));

        // ---- T6: reset mid-flight, stray core strobes are masked ----
        do_reset();
        req_x = 32'h4433_2211;
        for (int c = 0; c < 20; c++) begin
            rst = (c == 2);
            if (c <= 2) req_valid = 4'hF;
            else if (c == 10) req_valid = 4'b1010;
            else req_valid = 4'b0000;
            #1;
            if (c < 2) chk($sformatf("t6_ready_c%0d", c), {28'd0, req_ready}, 32'd1 << c);
            if (c == 2) chk("t6_ready_rst", {28'd0, req_ready}, 32'd0);
            if (c >= 2 && c <= 9) chk($sformatf("t6_busy_c%0d", c), {31'd0, busy}, 32'd0);
            if (c == 10) chk("t6_ready_ptr0", {28'd0, req_ready}, 32'h2);
            chk($sformatf("t6_err_c%0d", c), {31'd0, err}, 32'd0);
            step();
        end
        rst = 1'b0;
        chk("t6_count", rsp_q.size(), 32'd1);
        chk_rsp("t6_rsp0", 0, 15, 2'd1, y_of(8'h22));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
